// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 fetch/decode/execute sequencer.
// State encodings, opcode map, decoder load-enable bit positions and opcode legality.
package td4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

  localparam logic [3:0] ADD_A_IM = 4'b0000;
  localparam logic [3:0] MOV_A_B  = 4'b0001;
  localparam logic [3:0] IN_A     = 4'b0010;
  localparam logic [3:0] MOV_A_IM = 4'b0011;
  localparam logic [3:0] MOV_B_A  = 4'b0100;
  localparam logic [3:0] ADD_B_IM = 4'b0101;
  localparam logic [3:0] IN_B     = 4'b0110;
  localparam logic [3:0] MOV_B_IM = 4'b0111;
  localparam logic [3:0] OUT_B    = 4'b1001;
  localparam logic [3:0] OUT_IM   = 4'b1011;
  localparam logic [3:0] JNC      = 4'b1110;
  localparam logic [3:0] JMP      = 4'b1111;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  function automatic logic op_legal(input logic [3:0] opc);
    logic ok;
    case (opc)
      ADD_A_IM, MOV_A_B, IN_A, MOV_A_IM,
      MOV_B_A, ADD_B_IM, IN_B, MOV_B_IM,
      OUT_B, OUT_IM, JNC, JMP: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/td4_sequencer_if.sv
// Program ROM fetch handshake between the sequencer (master) and the ROM (slave).
interface td4_sequencer_if #(
  parameter int ROM_AW = 4
) ();

  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/td4_pc.sv
// Program counter: synchronous reset, load of the immediate, wrapping increment.
// Load wins when both enables are asserted.
module td4_pc #(
  parameter int ROM_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              inc_en,
  input  logic [ROM_AW-1:0] ld_val,
  output logic [ROM_AW-1:0] pc
);

  logic [ROM_AW-1:0] pc_d;
  logic [ROM_AW-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (ld_en) begin
      pc_d = ld_val;
    end else if (inc_en) begin
      pc_d = pc_q + ROM_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/decode/execute controller: owns PC, IR and carry, fetches over req/ack,
// and turns the decoder's active-low load enables into single-cycle EXEC strobes.
//
//   state  | meaning
//   IDLE   | waiting for run or step; halt_req holds it here
//   FETCH  | rom_req high at rom_addr = PC until rom_ack, IR captured on ack
//   DECODE | settle cycle for decoder and ALU, no strobes
//   EXEC   | strobes driven, PC and carry updated on the closing edge
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int ROM_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  td4_sequencer_if.master        rom,
  output logic [3:0]             op,
  output logic [3:0]             im,
  output logic                   c,
  input  logic [3:0]             dec_ld,
  input  logic                   alu_carry,
  output logic [2:0]             ld_n,
  output logic                   illegal,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_FETCH  = 2'(ST_FETCH);
  localparam logic [1:0] S_DECODE = 2'(ST_DECODE);
  localparam logic [1:0] S_EXEC   = 2'(ST_EXEC);

  logic [1:0]        state_d, state_q;
  logic [7:0]        ir_d, ir_q;
  logic              c_d, c_q;
  logic              step_mode_d, step_mode_q;
  logic              in_exec;
  logic              legal;
  logic              pc_ld;
  logic              pc_inc;
  logic [ROM_AW-1:0] pc;

  assign in_exec = (state_q == S_EXEC);
  assign legal   = op_legal(ir_q[7:4]);
  assign pc_ld   = in_exec && legal && !dec_ld[LD_PC];
  assign pc_inc  = in_exec && !pc_ld;

  td4_pc #(
    .ROM_AW (ROM_AW)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .ld_en  (pc_ld),
    .inc_en (pc_inc),
    .ld_val (ROM_AW'(ir_q[3:0])),
    .pc     (pc)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    c_d         = c_q;
    step_mode_d = step_mode_q;
    case (state_q)
      S_IDLE: begin
        if (!halt_req && (run || step)) begin
          state_d     = S_FETCH;
          step_mode_d = !run;
        end
      end
      S_FETCH: begin
        if (rom.rom_ack) begin
          ir_d    = rom.rom_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_carry;
        // halt and run are only sampled here, so an instruction always completes
        if (halt_req || step_mode_q || !run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= 8'h00;
      c_q         <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      c_q         <= c_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign rom.rom_req  = (state_q == S_FETCH);
  assign rom.rom_addr = pc;

  assign op      = ir_q[7:4];
  assign im      = ir_q[3:0];
  assign c       = c_q;
  assign ld_n    = (in_exec && legal) ? dec_ld[LD_OUT:LD_A] : 3'b111;
  assign illegal = in_exec && !legal;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Multi-cycle fetch/decode/execute controller for the TD4 4-bit CPU. It owns the program counter, instruction register and carry flag, and fetches 8-bit instructions from program ROM over a req/ack handshake. It feeds opcode and carry to the existing instruction decoder, then gates the decoder's active-low load enables into one-cycle register strobes. It also provides run, single-step and halt control.

## Interface
- `ROM_AW`, default 4: program address width; PC width equals ROM_AW.
- `clk` in, 1: the single clock; all state changes on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `run` in, 1: level; while high, execute instructions back-to-back.
- `step` in, 1: one-cycle pulse; in IDLE, execute exactly one instruction.
- `halt_req` in, 1: level; finish the current instruction, then return to IDLE.
- `rom_req` out, 1: fetch request; held high until acknowledged.
- `rom_addr` out, ROM_AW: equals PC; stable while rom_req is high.
- `rom_ack` in, 1: rom_data is valid in the cycle rom_ack is high.
- `rom_data` in, 8: instruction, with [7:4] = opcode and [3:0] = immediate.
- `op` out, 4: IR[7:4], to the decoder.
- `im` out, 4: IR[3:0], to the ALU and to the PC load value.
- `c` out, 1: carry flag, to the decoder.
- `dec_ld` in, 4: decoder load enables, active-low. Bit 0 = A, bit 1 = B, bit 2 = OUT, bit 3 = PC.
- `alu_carry` in, 1: adder carry-out for the current instruction.
- `ld_n` out, 3: gated active-low strobes for A, B and OUT (bit order as dec_ld[2:0]).
- `illegal` out, 1: one-cycle pulse in EXEC when the opcode is undefined.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE:
  - If halt_req is high, remain in IDLE.
  - Otherwise, if run or step is high, go to FETCH. run and step together are treated as run.
- FETCH:
  - rom_req = 1, rom_addr = PC.
  - On rom_ack = 1: IR <= rom_data, go to DECODE. rom_req drops the following cycle.
- DECODE: one settle cycle for the decoder and ALU. No strobes; ld_n = 3'b111.
- EXEC: one cycle.
  - ld_n = dec_ld[2:0] for legal opcodes; 3'b111 for illegal opcodes.
  - c <= alu_carry on every EXEC, legal or not.
  - If the opcode is legal and dec_ld[3] = 0, PC <= im. Otherwise PC <= PC + 1, wrapping from 2^ROM_AW−1 to 0.
  - Next state: IDLE if halt_req is high, the instruction was started by step, or run is low. Otherwise FETCH.
- Legal opcodes: 0000–0111, 1001, 1011, 1110, 1111. Every other opcode executes as a NOP with PC+1 and pulses `illegal`.
- A step pulse while busy is ignored. A step pulse is not queued.
- A halt_req raised mid-instruction never aborts FETCH, DECODE or EXEC. It takes effect only at the end of EXEC.
- Reset values: state IDLE, PC 0, IR 8'h00, c 0, rom_req 0, ld_n 3'b111, illegal 0, busy 0.
- rst asserted in any state, including mid-FETCH, returns every output to its reset value on the next edge. A pending ack is discarded.

## Timing
- Minimum instruction time is 3 cycles (FETCH with same-cycle ack, DECODE, EXEC). Each ROM wait cycle adds 1.
- Register strobes (ld_n low) last exactly one cycle and occur only in EXEC. The A/B/OUT registers capture on the edge that ends EXEC. PC and c update on the same edge.
- With `run` held high and zero wait, a new rom_req is issued every 3rd cycle, starting the cycle after EXEC.
- `op`, `im` and `c` are registered outputs, stable from DECODE through EXEC.

## Structure
- Shared package `td4_pkg`:
  - state enum;
  - opcode constants (ADD_A_IM, MOV_A_B, IN_A, MOV_A_IM, MOV_B_A, ADD_B_IM, IN_B, MOV_B_IM, OUT_B, OUT_IM, JNC, JMP);
  - LD bit indices (LD_A = 0, LD_B = 1, LD_OUT = 2, LD_PC = 3);
  - a legality function on the opcode.
- One sub-module, `td4_pc`: ROM_AW-bit register with synchronous reset, load (value im) and increment enables. Load has priority over increment.

## Test plan
- Reset, then run = 1, ROM[0] = 8'h35 (MOV A,5), immediate ack, dec_ld = 4'b1110 -> ld_n = 3'b110 for exactly one cycle, in cycle 3 after the first rom_req; PC = 1.
- JMP: ROM[1] = 8'hF9, dec_ld = 4'b0111 -> ld_n stays 3'b111, next rom_addr = 9. With PC = 15 running a non-jump, next rom_addr = 0 (wrap).
- ROM ack delayed 4 cycles -> rom_req held 4+ cycles with rom_addr constant; instruction takes 7 cycles; exactly one ld_n strobe.
- step pulse with run = 0 -> exactly one FETCH/DECODE/EXEC, then IDLE with busy = 0. A second step during DECODE is ignored.
- Opcode 1000 -> illegal pulses for 1 cycle, ld_n = 3'b111, PC+1. alu_carry = 1 in EXEC -> c = 1 afterwards.
- rst asserted mid-FETCH, and separately halt_req raised in DECODE -> reset: all outputs at reset values next cycle; halt: current EXEC completes, then IDLE with no further rom_req.
